// File: rtl/writeback_queue_if.sv
// writeback_queue_if: handshake and write-port bundle for writeback_queue.
// Result channels A/B:
//   iValidA/iResultA/oReadyA and iValidB/iResultB/oReadyB.
//   Each result is {dest[4:0], data[15:0]}.
// Register-file write ports:
//   oWritePort1/oRegWrite1 and oWritePort2/oRegWrite2.
// oCount reports the occupancy.
// WB_FORWARD_EN adds iFwdSel/oFwdHit/oFwdData for forwarding lookups.
interface writeback_queue_if #(
    parameter int DEPTH = 4
);
    logic                     iValidA;
    logic [20:0]              iResultA;
    logic                     oReadyA;
    logic                     iValidB;
    logic [20:0]              iResultB;
    logic                     oReadyB;
    logic                     oWritePort1;
    logic [20:0]              oRegWrite1;
    logic                     oWritePort2;
    logic [20:0]              oRegWrite2;
    logic [$clog2(DEPTH):0]   oCount;
`ifdef WB_FORWARD_EN
    logic [4:0]               iFwdSel;
    logic                     oFwdHit;
    logic [15:0]              oFwdData;
`endif

    modport slave (
`ifdef WB_FORWARD_EN
        input  iFwdSel,
        output oFwdHit, oFwdData,
`endif
        input  iValidA, iResultA, iValidB, iResultB,
        output oReadyA, oReadyB, oWritePort1, oRegWrite1, oWritePort2, oRegWrite2, oCount
    );

    modport master (
`ifdef WB_FORWARD_EN
        output iFwdSel,
        input  oFwdHit, oFwdData,
`endif
        output iValidA, iResultA, iValidB, iResultB,
        input  oReadyA, oReadyB, oWritePort1, oRegWrite1, oWritePort2, oRegWrite2, oCount
    );
endinterface

// File: rtl/writeback_queue.sv
// writeback_queue: two-in/two-out circular FIFO feeding two register-file write ports.
// Ports:
//   iClock - rising-edge clock.
//   iReset - synchronous active-high reset. It clears the pointers and count.
//   bus    - writeback_queue_if.slave.
//            Result channels A/B enqueue with A older than B.
//            Results targeting r0 are accepted and dropped.
//            Write port 1 issues the head entry.
//            Write port 2 issues head+1 when it targets a different register.
// Optional macro WB_FORWARD_EN adds a youngest-match forwarding lookup
// (iFwdSel -> oFwdHit/oFwdData).
module writeback_queue #(
    parameter int DEPTH = 4
) (
    input  logic             iClock,
    input  logic             iReset,
    writeback_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [20:0]   r_mem [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic          w_pushA;
    logic          w_pushB;
    logic          w_wp1;
    logic          w_wp2;
    logic [AW-1:0] w_head1;
    logic [AW-1:0] w_tailB;
    logic [20:0]   w_ent1;
    logic [20:0]   w_ent2;

    // Readiness depends only on the registered count, so same-cycle pops never widen it.
    assign bus.oReadyA = r_count <= CW'(DEPTH - 1);
    assign bus.oReadyB = r_count <= CW'(DEPTH - 2);
    assign bus.oCount  = r_count;

    // Register r0 is never written, so such results complete the handshake without a slot.
    assign w_pushA = bus.iValidA && bus.oReadyA && (bus.iResultA[20:16] != 5'd0);
    assign w_pushB = bus.iValidB && bus.oReadyB && (bus.iResultB[20:16] != 5'd0);
    assign w_tailB = r_tail + AW'(w_pushA);

    assign w_head1 = r_head + AW'(1);
    assign w_ent1  = r_mem[r_head];
    assign w_ent2  = r_mem[w_head1];

    // Two writes to one register in the same cycle would have undefined ordering.
    // The younger write therefore waits a cycle and issues on port 1.
    assign w_wp1 = r_count != CW'(0);
    assign w_wp2 = (r_count >= CW'(2)) && (w_ent2[20:16] != w_ent1[20:16]);

    assign bus.oWritePort1 = w_wp1;
    assign bus.oRegWrite1  = w_wp1 ? w_ent1 : '0;
    assign bus.oWritePort2 = w_wp2;
    assign bus.oRegWrite2  = w_wp2 ? w_ent2 : '0;

    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_pushA) r_mem[r_tail] <= bus.iResultA;
            if (w_pushB) r_mem[w_tailB] <= bus.iResultB;
            r_tail  <= r_tail + AW'(w_pushA) + AW'(w_pushB);
            r_head  <= r_head + AW'(w_wp1) + AW'(w_wp2);
            r_count <= r_count + CW'(w_pushA) + CW'(w_pushB) - CW'(w_wp1) - CW'(w_wp2);
        end
    end

`ifdef WB_FORWARD_EN
    // Scan oldest to youngest, so the last match found is the youngest.
    always_comb begin
        bus.oFwdHit  = 1'b0;
        bus.oFwdData = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < r_count) && (bus.iFwdSel != 5'd0) &&
                (r_mem[r_head + AW'(i)][20:16] == bus.iFwdSel)) begin
                bus.oFwdHit  = 1'b1;
                bus.oFwdData = r_mem[r_head + AW'(i)][15:0];
            end
        end
    end
`endif
endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 Parameter DEPTH, default 4; FIFO entry count, power of two, minimum 2.
REQ-002 iClock  input  1  clock; all state updates on rising edge.
REQ-003 iReset  input  1  reset, synchronous, active-high.
REQ-004 iValidA  input  1  result A presented this cycle.
REQ-005 iResultA  input  21  result A: [20:16] destination register, [15:0] data.
REQ-006 oReadyA  output  1  queue accepts result A this cycle.
REQ-007 iValidB / iResultB / oReadyB  input/input/output  1/21/1  second result channel; same meaning as A.
REQ-008 oWritePort1  output  1  write enable for register-file write port 1.
REQ-009 oRegWrite1  output  21  {register[4:0], data[15:0]} for write port 1.
REQ-010 oWritePort2 / oRegWrite2  output  1/21  same as REQ-008/009 for write port 2.
REQ-011 oCount  output  log2(DEPTH)+1  entries currently held.

Function
REQ-012 Circular FIFO of DEPTH 21-bit entries, head/tail pointers wrapping modulo DEPTH, registered count.
REQ-013 oReadyA = (DEPTH - count) >= 1; oReadyB = (DEPTH - count) >= 2; both from registered count only, independent of valid and of same-cycle pops.
REQ-014 Push A when iValidA && oReadyA; push B when iValidB && oReadyB; both in one cycle: A enqueued before B (A older).
REQ-015 Result with destination register 0 accepted (handshake completes) but not enqueued; count unaffected.
REQ-016 Write ports driven combinationally from FIFO contents: port 1 = head entry when count >= 1; port 2 = head+1 entry when count >= 2 and its register differs from head's register.
REQ-017 Same-register pair at head/head+1: only port 1 asserted; head+1 issues next cycle on port 1 (program order preserved, no lost write).
REQ-018 Every asserted write port pops its entry at the next edge; up to two pops per cycle.
REQ-019 Deasserted port drives oRegWrite = 0.
REQ-020 Latency: entry pushed at edge N appears on a write port during cycle N+1 earliest; register file captures it at edge N+1.
REQ-021 Simultaneous push and pop same cycle: count_next = count + pushes - pops; never exceeds DEPTH, never below 0.
REQ-022 Empty: both write ports deasserted; full: oReadyA = oReadyB = 0.
REQ-023 Pointer wrap from DEPTH-1 to 0 transparent: no entry lost or duplicated.

Reset
REQ-024 iReset high at edge: head, tail, count cleared to 0; entries held are discarded; pushes in that cycle ignored.
REQ-025 After reset: oCount = 0, oReadyA = oReadyB = 1, oWritePort1 = oWritePort2 = 0, oRegWrite1 = oRegWrite2 = 0.
REQ-026 Reset mid-drain: writes presented in the reset cycle still appear on ports combinationally, but no write issues in the cycle after reset.

Configuration
REQ-027 Macro WB_FORWARD_EN: when defined, adds iFwdSel (input, 5), oFwdHit (output, 1), oFwdData (output, 16).
REQ-028 With WB_FORWARD_EN: oFwdHit = 1 when any queued entry targets iFwdSel (nonzero); oFwdData = data of youngest such entry; otherwise oFwdHit = 0 and oFwdData = 0; combinational from FIFO contents.
REQ-029 Without WB_FORWARD_EN: ports of REQ-027 absent; all other behaviour identical.

Verification
REQ-030 Reset, then A = {r5, 0x1234} for one cycle -> next cycle oWritePort1 = 1, oRegWrite1 = {5, 0x1234}, oWritePort2 = 0; oCount returns to 0.
REQ-031 A = {r3, 0xAAAA} and B = {r4, 0xBBBB} same cycle -> next cycle port 1 = {3, 0xAAAA}, port 2 = {4, 0xBBBB}, both enabled.
REQ-032 A = {r7, 0x0001}, B = {r7, 0x0002} same cycle -> cycle 1 port 1 = {7, 0x0001}, port 2 off; cycle 2 port 1 = {7, 0x0002}.
REQ-033 DEPTH=4, push 4 entries with writes blocked by continuous refill across wrap -> oReadyA = 0 at count 4, oReadyB = 0 at count 3; all entries drain in order, none lost or duplicated.
REQ-034 A = {r0, 0xFFFF} -> oReadyA = 1, oCount stays 0, no write port asserted.
REQ-035 WB_FORWARD_EN, queue {r9, 0x0011} then {r9, 0x0022}, iFwdSel = 9 -> oFwdHit = 1, oFwdData = 0x0022; iReset mid-queue -> oFwdHit = 0 next cycle.
